// File: rtl/ntt_coeff_bank.sv
// Coefficient RAM with an in-place Cooley-Tukey butterfly driven by a four-beat
// address stream (read U, read L, write U, write L), plus a host load/unload port.
module ntt_coeff_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int Q      = 12289
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr_mode,
  input  logic [DATA_W-1:0] i_tw,
  input  logic              i_host_sel,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int N_BFLY = ADDR_W * (2 ** (ADDR_W - 1));
  localparam int CNT_W  = $clog2(N_BFLY + 1);
  localparam logic [1:0] PH_RD_U = 2'd0;
  localparam logic [1:0] PH_RD_L = 2'd1;
  localparam logic [1:0] PH_WR_U = 2'd2;
  localparam logic [1:0] PH_WR_L = 2'd3;
  localparam logic [2*DATA_W-1:0] Q_P = (2*DATA_W)'(Q);
  localparam logic [DATA_W:0]     Q_S = (DATA_W+1)'(Q);

  function automatic logic [DATA_W-1:0] mod_mul(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return DATA_W'(prod % Q_P);
  endfunction

  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_S) s = s - Q_S;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + Q_S - {1'b0, b};
    if (s >= Q_S) s = s - Q_S;
    return s[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_phase;
  logic [ADDR_W-1:0] r_u, r_l;
  logic [DATA_W-1:0] r_tw, r_a, r_b;
  logic              r_rd_vld_p0, r_rd_ph_p0;
  logic [DATA_W-1:0] r_rd_data_p0;
  logic              r_bf_vld_p1;
  logic [DATA_W-1:0] r_ap_p2, r_bp_p2;
  logic              r_wr_vld_p0, r_wr_we_p0, r_wr_ph_p0;
  logic [ADDR_W-1:0] r_wr_addr_p0;
  logic              r_wr_vld_p1, r_wr_we_p1, r_wr_ph_p1;
  logic [ADDR_W-1:0] r_wr_addr_p1;
  logic [CNT_W-1:0]  r_bfly_cnt;
  logic              r_done, r_err;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_accept, w_rd_beat, w_wr_beat, w_host_wr, w_busy;
  logic              w_addr_ok, w_err_beat;
  logic [DATA_W-1:0] w_t, w_rd_data;

  assign w_accept   = i_in_valid & ~i_host_sel;
  assign w_rd_beat  = w_accept & ~r_phase[1];
  assign w_wr_beat  = w_accept & r_phase[1];
  assign w_host_wr  = i_host_sel & i_host_we;
  assign w_busy     = (r_phase != PH_RD_U) | r_wr_vld_p0 | r_wr_vld_p1;
  assign w_addr_ok  = (r_phase == PH_WR_U) ? (i_addr == r_u) : (i_addr == r_l);
  assign w_err_beat = w_accept & ((i_wr_mode != r_phase[1]) | (r_phase[1] & ~w_addr_ok));
  assign w_t        = mod_mul(r_tw, r_b);

  // Writes still in flight shadow the RAM; the younger stage has priority.
  always_comb begin
    w_rd_data = r_mem[i_addr];
    if (r_wr_vld_p1 && r_wr_we_p1 && r_wr_addr_p1 == i_addr)
      w_rd_data = r_wr_ph_p1 ? r_bp_p2 : r_ap_p2;
    if (r_wr_vld_p0 && r_wr_we_p0 && r_wr_addr_p0 == i_addr)
      w_rd_data = r_wr_ph_p0 ? r_bp_p2 : r_ap_p2;
  end

  always_ff @(posedge clk) begin
    if (r_wr_vld_p1 && r_wr_we_p1)
      r_mem[r_wr_addr_p1] <= r_wr_ph_p1 ? r_bp_p2 : r_ap_p2;
    if (w_host_wr)
      r_mem[i_host_addr] <= i_host_wdata;
  end

  always_ff @(posedge clk) begin
    // p0: beat accepted, operand sampled / write address captured
    if (w_rd_beat) begin
      r_rd_data_p0 <= w_rd_data;
      r_rd_ph_p0   <= r_phase[0];
      if (r_phase == PH_RD_U) begin
        r_u  <= i_addr;
        r_tw <= i_tw;
      end
      if (r_phase == PH_RD_L) r_l <= i_addr;
    end
    if (w_wr_beat) begin
      r_wr_addr_p0 <= i_addr;
      r_wr_ph_p0   <= (r_phase == PH_WR_L);
      r_wr_we_p0   <= i_wr_mode;
    end
    // p1: operand lands in A/B; write beat moves toward commit
    if (r_rd_vld_p0) begin
      if (r_rd_ph_p0) r_b <= r_rd_data_p0;
      else            r_a <= r_rd_data_p0;
    end
    r_wr_addr_p1 <= r_wr_addr_p0;
    r_wr_ph_p1   <= r_wr_ph_p0;
    r_wr_we_p1   <= r_wr_we_p0;
    // p2: butterfly result
    if (r_bf_vld_p1) begin
      r_ap_p2 <= mod_add(r_a, w_t);
      r_bp_p2 <= mod_sub(r_a, w_t);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= PH_RD_U;
      r_rd_vld_p0  <= 1'b0;
      r_bf_vld_p1  <= 1'b0;
      r_wr_vld_p0  <= 1'b0;
      r_wr_vld_p1  <= 1'b0;
      r_bfly_cnt   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      if (w_accept) r_phase <= r_phase + 2'd1;
      r_rd_vld_p0  <= w_rd_beat;
      r_bf_vld_p1  <= r_rd_vld_p0 & r_rd_ph_p0;
      r_wr_vld_p0  <= w_wr_beat;
      r_wr_vld_p1  <= r_wr_vld_p0;
      r_done       <= 1'b0;
      if (r_wr_vld_p1 && r_wr_ph_p1) begin
        if (r_bfly_cnt == CNT_W'(N_BFLY - 1)) begin
          r_bfly_cnt <= '0;
          r_done     <= 1'b1;
        end else begin
          r_bfly_cnt <= r_bfly_cnt + 1'b1;
        end
      end
      if (w_err_beat || (w_host_wr && w_busy)) r_err <= 1'b1;
      r_host_rdata <= r_mem[i_host_addr];
    end
  end

  assign o_host_rdata = r_host_rdata;
  assign o_busy       = w_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_ntt_coeff_bank.sv
// Bench for ntt_coeff_bank: fixed butterfly vectors, forwarding hazard, protocol
// errors, mid-stream reset and a full randomized transform against a software model.
module tb_ntt_coeff_bank;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int Q      = 12289;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, wr_mode, host_sel, host_we;
  logic [ADDR_W-1:0] addr, host_addr;
  logic [DATA_W-1:0] tw, host_wdata, host_rdata;
  logic              busy, done, err;

  ntt_coeff_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .Q(Q)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(in_valid), .i_addr(addr), .i_wr_mode(wr_mode), .i_tw(tw),
    .i_host_sel(host_sel), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata),
    .o_host_rdata(host_rdata), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_beat_cyc = 0;
  int mm [256];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end

  typedef struct {
    int u; int l; int a; int b; int tw; int exp_u; int exp_l;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; host_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic host_write(input int a, input int d);
    host_sel = 1'b1; host_we = 1'b1; host_addr = 8'(a); host_wdata = 16'(d);
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input int a, output int d);
    host_sel = 1'b1; host_we = 1'b0; host_addr = 8'(a);
    tick();
    d = int'(host_rdata);
  endtask

  task automatic beat(input int a, input logic wm, input int t, input int bub);
    int n;
    n = (bub > 0) ? int'($urandom_range(bub, 0)) : 0;
    host_sel = 1'b0; host_we = 1'b0;
    repeat (n) idle(1);
    in_valid = 1'b1; addr = 8'(a); wr_mode = wm; tw = 16'(t);
    last_beat_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic stream_bfly(input int u, input int l, input int t, input int bub);
    beat(u, 1'b0, t, bub);
    beat(l, 1'b0, 0, bub);
    beat(u, 1'b1, 0, bub);
    beat(l, 1'b1, 0, bub);
  endtask

  function automatic int mmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p % longint'(Q));
  endfunction

  task automatic model_bfly(input int u, input int l, input int t);
    int tt, a;
    tt = mmul(t, mm[l]);
    a = mm[u];
    mm[u] = (a + tt) % Q;
    mm[l] = (a - tt + Q) % Q;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  initial begin
    int rd, len, t, p3;
    rst = 1'b1; in_valid = 1'b0; wr_mode = 1'b0; host_sel = 1'b0; host_we = 1'b0;
    addr = '0; host_addr = '0; tw = '0; host_wdata = '0;
    repeat (2) tick();
    check("reset_rdata", int'(host_rdata), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0; tick();

    vecs[0] = '{8'h80, 8'h00, 5, 3, 2, 11, 12288};
    vecs[1] = '{8'h11, 8'h91, 12000, 12000, 12000, 9498, 2213};
    vecs[2] = '{8'h12, 8'h92, 0, 0, 0, 0, 0};
    vecs[3] = '{8'h13, 8'h93, 12288, 12288, 12288, 0, 12287};
    vecs[4] = '{8'h14, 8'h94, 1, 0, 5, 1, 1};
    vecs[5] = '{8'h15, 8'h95, 0, 1, 1, 1, 12288};
    vecs[6] = '{8'h16, 8'h96, 100, 200, 3, 700, 11789};
    for (int i = 0; i < 7; i++) begin
      host_write(vecs[i].u, vecs[i].a);
      host_write(vecs[i].l, vecs[i].b);
      stream_bfly(vecs[i].u, vecs[i].l, vecs[i].tw, 0);
      idle(4);
      host_read(vecs[i].u, rd); check($sformatf("vec%0d_u", i), rd, vecs[i].exp_u);
      host_read(vecs[i].l, rd); check($sformatf("vec%0d_l", i), rd, vecs[i].exp_l);
      check($sformatf("vec%0d_err", i), int'(err), 0);
    end

    // back-to-back butterflies sharing 0x00: second read must see the forwarded B'
    foreach (mm[i]) mm[i] = 0;
    mm[8'h80] = int'($urandom_range(Q - 1));
    mm[8'h00] = int'($urandom_range(Q - 1));
    mm[8'h40] = int'($urandom_range(Q - 1));
    host_write(8'h80, mm[8'h80]); host_write(8'h00, mm[8'h00]); host_write(8'h40, mm[8'h40]);
    t = int'($urandom_range(Q - 1));
    stream_bfly(8'h80, 8'h00, t, 0); model_bfly(8'h80, 8'h00, t);
    t = int'($urandom_range(Q - 1));
    stream_bfly(8'h00, 8'h40, t, 0); model_bfly(8'h00, 8'h40, t);
    idle(4);
    host_read(8'h80, rd); check("hazard_80", rd, mm[8'h80]);
    host_read(8'h00, rd); check("hazard_00", rd, mm[8'h00]);
    host_read(8'h40, rd); check("hazard_40", rd, mm[8'h40]);
    check("hazard_err", int'(err), 0);

    // protocol errors
    do_reset();
    beat(8'h10, 1'b1, 7, 0);
    check("err_wrmode_next", int'(err), 1);
    idle(3);
    check("err_wrmode_sticky", int'(err), 1);
    do_reset();
    beat(8'h10, 1'b0, 7, 0);
    beat(8'h20, 1'b0, 0, 0);
    check("err_before_addr", int'(err), 0);
    beat(8'h11, 1'b1, 0, 0);
    check("err_addr_u", int'(err), 1);
    do_reset();
    beat(8'h10, 1'b0, 7, 0);
    check("busy_mid", int'(busy), 1);
    host_write(8'h55, 1);
    check("err_host_busy", int'(err), 1);

    // async reset after phase 1
    do_reset();
    host_write(8'h22, 7); host_write(8'h33, 9);
    host_read(8'h22, rd); check("pre_rst_rdata", rd, 7);
    beat(8'h22, 1'b0, 4, 0);
    beat(8'h33, 1'b0, 0, 0);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1; #1;
    check("midrst_rdata", int'(host_rdata), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    stream_bfly(8'h22, 8'h33, 4, 0);
    idle(4);
    host_read(8'h22, rd); check("post_rst_u", rd, 43);
    host_read(8'h33, rd); check("post_rst_l", rd, 12260);
    check("post_rst_err", int'(err), 0);

    // full transform with random data, twiddles and bubbles
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mm[i] = int'($urandom_range(Q - 1));
      host_write(i, mm[i]);
    end
    idle(1);
    p3 = done_cnt;
    for (int s = 0; s < ADDR_W; s++) begin
      len = 128 >> s;
      for (int st = 0; st < 256; st += 2 * len)
        for (int j = st; j < st + len; j++) begin
          t = int'($urandom_range(Q - 1));
          stream_bfly(j, j + len, t, 2);
          model_bfly(j, j + len, t);
        end
    end
    t = last_beat_cyc;
    idle(6);
    check("full_done_count", done_cnt - p3, 1);
    check("full_done_cycle", done_cyc, t + 3);
    check("full_busy", int'(busy), 0);
    check("full_err", int'(err), 0);
    for (int i = 0; i < 256; i++) begin
      host_read(i, rd);
      check($sformatf("full_mem[%0d]", i), rd, mm[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
